// File: rtl/seg_pkg.sv
// Seven-segment definitions shared by the display path and the scan reader.
// Patterns are active-low: a 0 bit means the segment is lit.
package seg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_pattern_t;

    typedef enum logic [2:0] {
        SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G
    } seg_bit_e;

    localparam seg_pattern_t GLYPH_0 = 7'h40;
    localparam seg_pattern_t GLYPH_1 = 7'h79;
    localparam seg_pattern_t GLYPH_2 = 7'h24;
    localparam seg_pattern_t GLYPH_3 = 7'h30;
    localparam seg_pattern_t GLYPH_4 = 7'h19;
    localparam seg_pattern_t GLYPH_5 = 7'h12;
    localparam seg_pattern_t GLYPH_6 = 7'h02;
    localparam seg_pattern_t GLYPH_7 = 7'h78;
    localparam seg_pattern_t GLYPH_8 = 7'h00;
    localparam seg_pattern_t GLYPH_9 = 7'h10;
    localparam seg_pattern_t GLYPH_A = 7'h08;
    localparam seg_pattern_t GLYPH_B = 7'h03;
    localparam seg_pattern_t GLYPH_C = 7'h46;
    localparam seg_pattern_t GLYPH_D = 7'h21;
    localparam seg_pattern_t GLYPH_E = 7'h06;
    localparam seg_pattern_t GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg7_to_nibble.sv
// Inverse seven-segment decode: active-low pattern to hex nibble.
// Patterns outside the glyph set raise err_o and return nibble 0.
module seg7_to_nibble
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_n_i,
    output logic             err_o,
    output logic [3:0]       nibble_o
);

    always_comb begin
        err_o    = 1'b0;
        nibble_o = 4'h0;
        case (seg_n_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reads hex digits back from a scanned active-low seven-segment bus,
// debouncing each digit and emitting one frame per complete scan.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NUM_DIGITS-1:0]   scan_sel,
    input  logic [SEG_W-1:0]        seg_n,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   sel_q;
    seg_pattern_t            seg_q;
    logic [7:0]              run_q, run_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   derr_q, derr_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    valid_q, valid_d;

    logic       same_pair, accept, xfer;
    logic       dec_err;
    logic [3:0] dec_nibble;

    // At an acceptance the live pair equals the sampled one, so decoding
    // the sample register yields the accepted digit.
    seg7_to_nibble u_decode (
        .seg_n_i  (seg_q),
        .err_o    (dec_err),
        .nibble_o (dec_nibble)
    );

    always_comb begin
        same_pair = (scan_sel == sel_q) && (seg_n == seg_q);

        if (!same_pair)          run_d = 8'd1;
        else if (run_q >= STABLE) run_d = STABLE;
        else                     run_d = run_q + 8'd1;

        // Fires once per dwell: only the step from STABLE-1 to STABLE counts.
        accept = same_pair && $onehot(scan_sel) && (run_q == STABLE - 8'd1);

        digit_d = digit_q;
        derr_d  = derr_q;
        mask_d  = mask_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept && scan_sel[i]) begin
                digit_d[4*i +: 4] = dec_nibble;
                derr_d[i]         = dec_err;
                mask_d[i]         = 1'b1;
            end
        end

        // Handshake: a frame moves when out_valid && out_ready on the same edge;
        // while out_valid && !out_ready, out_value/out_err are held unchanged.
        xfer = (&mask_q) && (!valid_q || out_ready);

        value_d = value_q;
        err_d   = err_q;
        valid_d = valid_q && !out_ready;
        if (xfer) begin
            value_d = digit_d;
            err_d   = derr_d;
            valid_d = 1'b1;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_q   <= '0;
            seg_q   <= '0;
            run_q   <= '0;
            mask_q  <= '0;
            digit_q <= '0;
            derr_q  <= '0;
            value_q <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= scan_sel;
            seg_q   <= seg_n;
            run_q   <= run_d;
            mask_q  <= mask_d;
            digit_q <= digit_d;
            derr_q  <= derr_d;
            value_q <= value_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign out_value = value_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed scenarios plus randomized dwells
// checked against a history-based reference model.
module tb_seg_scan_reader;

    localparam int ND = 6;
    localparam int SC = 4;
    localparam int FW = 5 * ND;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [ND-1:0]   scan_sel = '0;
    logic [6:0]      seg_n = '0;
    logic [4*ND-1:0] out_value;
    logic [ND-1:0]   out_err;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .scan_sel  (scan_sel),
        .seg_n     (seg_n),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- reference model ----------------
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [ND+6:0]   hist [$];
    logic [3:0]      m_digit [ND];
    logic            m_derr [ND];
    logic [ND-1:0]   m_mask;
    logic            m_valid;
    logic [4*ND-1:0] m_value;
    logic [ND-1:0]   m_err;
    logic [FW-1:0]   exp_q [$];
    logic [FW-1:0]   pop_q [$];

    // Observations gathered per step
    int              valid_cycles;
    int              first_valid_step;
    int              step_no;
    logic [4*ND-1:0] cap_value;
    logic [ND-1:0]   cap_err;

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        pop_q.delete();
        for (int i = 0; i < ND; i++) begin
            m_digit[i] = 4'h0;
            m_derr[i]  = 1'b0;
        end
        m_mask  = '0;
        m_valid = 1'b0;
        m_value = '0;
        m_err   = '0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic [ND+6:0] pair;
        int            run;
        bit            still;
        bit            acc;
        int            idx;
        logic [3:0]    nib;
        bit            bad;
        bit            full;
        bit            slot_free;
        pair = {scan_sel, seg_n};
        hist.push_back(pair);
        if (hist.size() > SC + 2) void'(hist.pop_front());
        run   = 0;
        still = 1'b1;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (still && hist[k] == pair) run++;
            else still = 1'b0;
        end
        acc = (run == SC) && ($countones(scan_sel) == 1);
        idx = 0;
        for (int i = 0; i < ND; i++) if (scan_sel[i]) idx = i;
        nib = 4'h0;
        bad = 1'b1;
        for (int v = 0; v < 16; v++) begin
            if (glyph_tab[v] == seg_n) begin
                nib = 4'(v);
                bad = 1'b0;
            end
        end
        full      = (m_mask == {ND{1'b1}});
        slot_free = !m_valid || out_ready;
        if (acc) begin
            m_digit[idx] = nib;
            m_derr[idx]  = bad;
        end
        if (full && slot_free) begin
            for (int i = 0; i < ND; i++) begin
                m_value[4*i +: 4] = m_digit[i];
                m_err[i]          = m_derr[i];
            end
            m_valid = 1'b1;
            m_mask  = '0;
            exp_q.push_back({m_err, m_value});
        end else begin
            if (acc) m_mask[idx] = 1'b1;
            if (m_valid && out_ready) m_valid = 1'b0;
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [ND-1:0] onehot(input int i);
        logic [ND-1:0] s;
        s    = '0;
        s[i] = 1'b1;
        return s;
    endfunction

    task automatic clear_obs();
        valid_cycles     = 0;
        first_valid_step = -1;
        step_no          = 0;
        cap_value        = '0;
        cap_err          = '0;
    endtask

    task automatic step(input logic [ND-1:0] sel, input logic [6:0] seg, input logic rdy);
        scan_sel  = sel;
        seg_n     = seg;
        out_ready = rdy;
        if (out_valid && out_ready) pop_q.push_back({out_err, out_value});
        @(posedge clock);
        model_edge();
        #1;
        if (out_valid) begin
            valid_cycles++;
            if (first_valid_step < 0) first_valid_step = step_no;
            cap_value = out_value;
            cap_err   = out_err;
        end
        step_no++;
    endtask

    task automatic scan(input logic [7*ND-1:0] gls, input logic rdy);
        for (int i = 0; i < ND; i++)
            for (int k = 0; k < SC; k++) step(onehot(i), gls[7*i +: 7], rdy);
    endtask

    task automatic flush(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step('0, 7'h7F, rdy);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        scan_sel  = '0;
        seg_n     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        model_reset();
        clear_obs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_value !== '0) begin
            errors++; $display("FAIL reset_value: got %h want 0", out_value);
        end
        checks++;
        if (out_err !== '0) begin
            errors++; $display("FAIL reset_err: got %b want 0", out_err);
        end
    endtask

    task automatic test_basic_scan();
        logic [7*ND-1:0] gls;
        gls = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        do_reset();
        for (int i = 0; i < ND + 1; i++) begin
            for (int k = 0; k < SC; k++) begin
                if (i < ND) step(onehot(i), gls[7*i +: 7], 1'b1);
                else        step('0, 7'h7F, 1'b1);
                checks++;
                if (out_valid !== m_valid || out_value !== m_value || out_err !== m_err) begin
                    errors++;
                    $display("FAIL basic_model step%0d: got v=%b %h %b want v=%b %h %b",
                             step_no, out_valid, out_value, out_err, m_valid, m_value, m_err);
                end
            end
        end
        checks++;
        if (valid_cycles != 1 || first_valid_step != ND * SC) begin
            errors++;
            $display("FAIL basic_timing: valid_cycles=%0d first=%0d want 1 at %0d",
                     valid_cycles, first_valid_step, ND * SC);
        end
        checks++;
        if (cap_value !== 24'h543210 || cap_err !== 6'b000000) begin
            errors++;
            $display("FAIL basic_frame: got %h/%b want 543210/000000", cap_value, cap_err);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int k = 0; k < SC; k++) step(onehot(0), 7'h40, 1'b1);
        for (int k = 0; k < SC; k++) step(onehot(1), 7'h79, 1'b1);
        for (int k = 0; k < 3; k++)  step(onehot(2), 7'h24, 1'b1);
        for (int k = 0; k < SC; k++) step(onehot(2), 7'h30, 1'b1);
        for (int k = 0; k < SC; k++) step(onehot(3), 7'h30, 1'b1);
        for (int k = 0; k < SC; k++) step(onehot(4), 7'h19, 1'b1);
        for (int k = 0; k < SC; k++) step(onehot(5), 7'h12, 1'b1);
        flush(2, 1'b1);
        checks++;
        if (valid_cycles != 1 || cap_value !== 24'h543310 || cap_err !== '0) begin
            errors++;
            $display("FAIL glitch_frame: cycles=%0d got %h/%b want 1 543310/000000",
                     valid_cycles, cap_value, cap_err);
        end
    endtask

    task automatic test_illegal();
        logic [7*ND-1:0] gls;
        gls = {7'h08, 7'h7F, 7'h08, 7'h08, 7'h08, 7'h08};
        do_reset();
        scan(gls, 1'b1);
        flush(2, 1'b1);
        checks++;
        if (valid_cycles != 1 || cap_value !== 24'hA0AAAA || cap_err !== 6'b010000) begin
            errors++;
            $display("FAIL illegal_frame: cycles=%0d got %h/%b want 1 A0AAAA/010000",
                     valid_cycles, cap_value, cap_err);
        end
    endtask

    task automatic test_backpressure();
        logic [7*ND-1:0] g8;
        logic [7*ND-1:0] gf;
        bit              held_ok;
        g8 = {ND{7'h00}};
        gf = {ND{7'h0E}};
        do_reset();
        scan(g8, 1'b0);
        held_ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            for (int k = 0; k < SC; k++) begin
                step(onehot(i), gf[7*i +: 7], 1'b0);
                if (out_valid !== 1'b1 || out_value !== 24'h888888 || out_err !== '0) held_ok = 1'b0;
            end
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL bp_hold: last v=%b %h want 1 888888 throughout", out_valid, out_value);
        end
        step('0, 7'h7F, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 24'hFFFFFF || out_err !== '0) begin
            errors++;
            $display("FAIL bp_second: got v=%b %h/%b want 1 FFFFFF/000000", out_valid, out_value, out_err);
        end
        step('0, 7'h7F, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_bad_sel();
        logic [7*ND-1:0] gls;
        gls = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        do_reset();
        for (int k = 0; k < 10; k++) step('0, 7'h40, 1'b1);
        for (int k = 0; k < 10; k++) step(6'b000011, 7'h40, 1'b1);
        for (int i = 2; i < ND; i++)
            for (int k = 0; k < SC; k++) step(onehot(i), gls[7*i +: 7], 1'b1);
        flush(2, 1'b1);
        checks++;
        if (valid_cycles != 0) begin
            errors++; $display("FAIL badsel_nocapture: valid_cycles=%0d want 0", valid_cycles);
        end
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < SC; k++) step(onehot(i), gls[7*i +: 7], 1'b1);
        flush(2, 1'b1);
        checks++;
        if (valid_cycles != 1 || cap_value !== 24'h543210) begin
            errors++;
            $display("FAIL badsel_complete: cycles=%0d got %h want 1 543210", valid_cycles, cap_value);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        scan({ND{7'h10}}, 1'b0);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < SC; k++) step(onehot(i), 7'h06, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 24'h999999) begin
            errors++; $display("FAIL rstmid_pre: got v=%b %h want 1 999999", out_valid, out_value);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_value !== '0 || out_err !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b %h/%b want 0 000000/000000", out_valid, out_value, out_err);
        end
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        model_reset();
        clear_obs();
        for (int i = 3; i < ND; i++)
            for (int k = 0; k < SC; k++) step(onehot(i), 7'h02, 1'b1);
        flush(2, 1'b1);
        checks++;
        if (valid_cycles != 0) begin
            errors++; $display("FAIL rstmid_partial: valid_cycles=%0d want 0", valid_cycles);
        end
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < SC; k++) step(onehot(i), 7'h02, 1'b1);
        flush(2, 1'b1);
        checks++;
        if (valid_cycles != 1 || cap_value !== 24'h666666 || cap_err !== '0) begin
            errors++;
            $display("FAIL rstmid_frame: cycles=%0d got %h/%b want 1 666666/000000",
                     valid_cycles, cap_value, cap_err);
        end
    endtask

    task automatic test_random();
        logic [ND-1:0]  sel;
        logic [6:0]     seg;
        int             len;
        int             bad_steps;
        logic [FW-1:0]  got;
        logic [FW-1:0]  want;
        do_reset();
        bad_steps = 0;
        for (int d = 0; d < 300; d++) begin
            if ($urandom_range(0, 99) < 85) sel = onehot($urandom_range(0, ND - 1));
            else                            sel = ND'($urandom_range(0, (1 << ND) - 1));
            if ($urandom_range(0, 99) < 80) seg = glyph_tab[$urandom_range(0, 15)];
            else                            seg = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                step(sel, seg, ($urandom_range(0, 3) != 0));
                checks++;
                if (out_valid !== m_valid || out_value !== m_value || out_err !== m_err) begin
                    errors++;
                    if (bad_steps < 10)
                        $display("FAIL random_model step%0d: got v=%b %h %b want v=%b %h %b",
                                 step_no, out_valid, out_value, out_err, m_valid, m_value, m_err);
                    bad_steps++;
                end
            end
        end
        while (pop_q.size() > 0) begin
            got = pop_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL random_pop: got %h with no expected frame", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++; $display("FAIL random_pop: got %h want %h", got, want);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        clear_obs();
        test_reset();
        test_basic_scan();
        test_glitch();
        test_illegal();
        test_backpressure();
        test_bad_sel();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Recovers hex digits from a multiplexed, active-low seven-segment display bus, the inverse of the nibble-to-segment decode used on the display path. The block samples a scanned segment bus and debounces each digit's pattern. It maps the pattern back to a 4-bit value, flags patterns that are not legal hex glyphs, and emits one assembled frame per complete scan over a valid/ready handshake. It sits beside the score/display path for self-check and for reading scores back into game logic.

## Interface

- NUM_DIGITS, 6: digits on the scanned bus; 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted; 2..255.
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- scan_sel  in  NUM_DIGITS  one-hot digit select of the bus; bit i means seg_n belongs to digit i.
- seg_n  in  7  active-low segments, bit0=a … bit6=g (0 = lit).
- out_value  out  4*NUM_DIGITS  digit i in bits [4i+3:4i].
- out_err  out  NUM_DIGITS  bit i set means digit i's accepted pattern was not a legal glyph; the nibble reads 0.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame when high together with out_valid.

## Operation

- Legal glyphs (seg_n hex, value): 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 08=A, 03=b, 46=C, 21=d, 06=E, 0E=F. Any other pattern is an error and yields nibble 0.
- Sample register: holds the previous (scan_sel, seg_n) pair.
- Run counter: 8 bits, saturating at STABLE_CYCLES.
  - If the current pair equals the previous pair, the counter increments.
  - Otherwise the counter loads 1.
- Acceptance: occurs on the edge at which the run counter reaches exactly STABLE_CYCLES and scan_sel is one-hot. Only one acceptance happens per dwell; a dwell lasting longer never re-accepts.
- scan_sel that is zero or multi-hot is never accepted. It still resets the run.
- On acceptance of digit i:
  - the digit register i and the error bit i load;
  - captured-mask bit i sets;
  - a re-accept of an already captured digit overwrites it, so the latest value wins.
- Frame transfer happens when the mask is all ones and the output slot is free (!out_valid, or out_valid && out_ready on the same edge). On transfer:
  - out_value and out_err load from the digit registers, including an acceptance occurring on the same edge;
  - out_valid sets;
  - the mask clears.
- Stall: while the mask is full and the output slot is held, captures keep overwriting the digit registers. The mask stays full, and the transfer fires on the first edge the slot frees.
- Handshake: out_value and out_err are stable while out_valid && !out_ready. A pop with no pending frame clears out_valid.
- States are implicit: COLLECT (mask not full), FULL (mask full, output busy), plus the output slot EMPTY/VALID.

## Timing

- Reset values: out_valid=0, out_value=0, out_err=0, mask=0, run counter=0, sample register=0. Reset mid-frame discards all partial captures.
- Acceptance latency: a pair first presented on edge t is accepted at edge t+STABLE_CYCLES-1.
- Frame latency: out_valid is high one edge after the acceptance that completes the mask, if the slot is free.
- Throughput: one frame per full scan. Back-to-back frames are possible with out_ready tied high.

## Structure

- Shared package seg_pkg:
  - the 16 glyph constants;
  - the segment bit-order definition;
  - the 7-bit pattern type, also used by the display path.
- Sub-module seg7_to_nibble: combinational, seg_n in → {err, nibble} out, instantiated once on the sampled pattern.

## Test plan

- Reset, then scan digits 0..5 with glyphs 40,79,24,30,19,12, each held for 4 cycles, out_ready=1. Required: out_value=0x543210, out_err=0, out_valid high for one cycle after the last acceptance.
- Glitch: digit 2 shows 24 for 3 cycles, then 30 for 4 cycles. Required: only 3 is accepted, so digit 2 reads 3.
- Illegal pattern 7F on digit 4 within a full scan of 08. Required: out_err=6'b010000 and nibble 4 reads 0; other nibbles read A.
- Backpressure: out_ready=0 across two complete scans (first all 00, second all 0E), then out_ready=1. Required: first frame 0x888888 held stable, then second frame 0xFFFFFF on the next edge.
- scan_sel=0 and scan_sel=6'b000011 each held for 10 cycles. Required: no captures and out_valid stays 0.
- resetn pulsed low after 3 digits are captured, then a full scan is applied. Required: outputs return to 0 and a frame appears only after all 6 digits are recaptured.
